// File: rtl/eth_stats_log_arbiter_pkg.sv
// Constants shared by the eth_stats log path (collectors and the log arbiter).
package eth_stats_log_arbiter_pkg;

  localparam int unsigned LOG_AXIS_WIDTH_DEFAULT = 64;
  localparam int unsigned LOG_MAX_SOURCES        = 8;
  localparam int unsigned LOG_IDX_WIDTH          = 3;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_STREAM = 1'b1
  } arb_state_e;

endpackage

// File: rtl/eth_stats_log_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: first asserted request after last_idx, wrapping at N.
module rr_priority_encoder
  import eth_stats_log_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = LOG_IDX_WIDTH
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic [N-1:0]     grant_onehot_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_valid_o
);

  int unsigned base;
  int unsigned cand;
  logic        found;

  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    found          = 1'b0;
    // An out-of-range last index behaves like N-1, so the search starts at 0.
    base = (32'(last_idx_i) < N) ? 32'(last_idx_i) : N - 1;
    cand = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (base + off >= N) ? base + off - N : base + off;
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && (i == cand) && req_i[i]) begin
          found             = 1'b1;
          grant_onehot_o[i] = 1'b1;
          grant_idx_o       = IDX_W'(i);
        end
      end
    end
    any_valid_o = found;
  end

endmodule

// File: rtl/eth_stats_log_arbiter.sv
// Packet-aware round-robin merge of the collector log streams; beats tagged with source index on tdest.
module eth_stats_log_arbiter
  import eth_stats_log_arbiter_pkg::*;
#(
  parameter int unsigned C_NUM_INPUTS     = 4,
  parameter int unsigned C_AXIS_LOG_WIDTH = LOG_AXIS_WIDTH_DEFAULT,
  parameter int unsigned C_IDX_WIDTH      = LOG_IDX_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [C_NUM_INPUTS-1:0]                  enable_mask,
  input  logic [C_NUM_INPUTS*C_AXIS_LOG_WIDTH-1:0] s_axis_log_tdata,
  input  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tlast,
  input  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tvalid,
  output logic [C_NUM_INPUTS-1:0]                  s_axis_log_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0]              m_axis_log_tdata,
  output logic [C_IDX_WIDTH-1:0]                   m_axis_log_tdest,
  output logic                                     m_axis_log_tlast,
  output logic                                     m_axis_log_tvalid,
  input  logic                                     m_axis_log_tready,
  output logic                                     busy,
  output logic [31:0]                              packet_count
);

  localparam int unsigned N  = C_NUM_INPUTS;
  localparam int unsigned W  = C_AXIS_LOG_WIDTH;
  localparam int unsigned IW = C_IDX_WIDTH;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [N-1:0]  grant_oh_q, grant_oh_d;

  logic [W-1:0]  m_data_q;
  logic [IW-1:0] m_dest_q;
  logic          m_last_q;
  logic          m_valid_q;
  logic [31:0]   packet_count_q;

  logic [N-1:0]  rr_onehot;
  logic [IW-1:0] rr_idx;
  logic          rr_any;

  logic          out_ready;
  logic          sel_valid;
  logic          sel_last;
  logic [W-1:0]  sel_data;
  logic [N-1:0]  s_ready;
  logic          accept;

  // grant_q doubles as the last-granted index for the next search.
  rr_priority_encoder #(
    .N     (N),
    .IDX_W (IW)
  ) u_rr (
    .req_i          (s_axis_log_tvalid & enable_mask),
    .last_idx_i     (grant_q),
    .grant_onehot_o (rr_onehot),
    .grant_idx_o    (rr_idx),
    .any_valid_o    (rr_any)
  );

  assign out_ready = ~m_valid_q | m_axis_log_tready;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    s_ready   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_oh_q[i]) begin
        sel_valid = s_axis_log_tvalid[i];
        sel_last  = s_axis_log_tlast[i];
        sel_data  = s_axis_log_tdata[i*W +: W];
      end
    end
    if (state_q == ARB_STREAM) begin
      s_ready = grant_oh_q & {N{out_ready}};
    end
  end

  assign accept = (state_q == ARB_STREAM) && sel_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    case (state_q)
      ARB_IDLE: begin
        if (rr_any) begin
          grant_d    = rr_idx;
          grant_oh_d = rr_onehot;
          state_d    = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        if (accept && sel_last) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= IW'(N - 1);
      grant_oh_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
    end
  end

  // A load takes priority over a drain, giving one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_dest_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= sel_data;
      m_dest_q  <= grant_q;
      m_last_q  <= sel_last;
    end else if (m_valid_q && m_axis_log_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      packet_count_q <= '0;
    end else if (m_valid_q && m_axis_log_tready && m_last_q) begin
      packet_count_q <= packet_count_q + 32'd1;
    end
  end

  assign s_axis_log_tready = s_ready;
  assign m_axis_log_tdata  = m_data_q;
  assign m_axis_log_tdest  = m_dest_q;
  assign m_axis_log_tlast  = m_last_q;
  assign m_axis_log_tvalid = m_valid_q;
  assign busy              = (state_q == ARB_STREAM);
  assign packet_count      = packet_count_q;

endmodule

// File: tb/tb_eth_stats_log_arbiter.sv
// Self-checking bench for eth_stats_log_arbiter: per-source packet queues, scoreboard and round-robin model.
module tb_eth_stats_log_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  enable_mask;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]  s_tlast;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tready;
  logic [W-1:0]  m_tdata;
  logic [IW-1:0] m_tdest;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic          busy;
  logic [31:0]   packet_count;

  always #5 clk = ~clk;

  eth_stats_log_arbiter #(
    .C_NUM_INPUTS     (N),
    .C_AXIS_LOG_WIDTH (W),
    .C_IDX_WIDTH      (IW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable_mask       (enable_mask),
    .s_axis_log_tdata  (s_tdata),
    .s_axis_log_tlast  (s_tlast),
    .s_axis_log_tvalid (s_tvalid),
    .s_axis_log_tready (s_tready),
    .m_axis_log_tdata  (m_tdata),
    .m_axis_log_tdest  (m_tdest),
    .m_axis_log_tlast  (m_tlast),
    .m_axis_log_tvalid (m_tvalid),
    .m_axis_log_tready (m_tready),
    .busy              (busy),
    .packet_count      (packet_count)
  );

  int checks = 0;
  int errors = 0;

  // Pending source beats and beats accepted by the DUT but not yet seen at the output.
  logic [W-1:0] src_data [N][$];
  logic         src_last [N][$];
  logic [W-1:0] sb_data  [N][$];
  logic         sb_last  [N][$];

  int           owner, owner_next, last_grant;
  logic [31:0]  exp_cnt;
  logic         exp_load, exp_ldst;
  logic [W-1:0] exp_data;
  logic [IW-1:0] exp_dest;
  logic         prev_mv, prev_mr, prev_last;
  logic [W-1:0] prev_data;
  logic [IW-1:0] prev_dest;
  int           cyc, vprob, rprob, stall_from, stall_to, stall_seen;
  int           out_dest[$];
  int           out_cycle[$];
  int           in_cycle[$];
  int           pk_src[N];
  int           beats_src[N];
  int           in_src[N];
  bit           clr_bit1;

  task automatic model_reset();
    owner = -1; owner_next = -1; last_grant = N - 1;
    exp_cnt = '0; exp_load = 1'b0; exp_ldst = 1'b0; exp_data = '0; exp_dest = '0;
    prev_mv = 1'b0; prev_mr = 1'b0; prev_last = 1'b0; prev_data = '0; prev_dest = '0;
    cyc = 0; stall_from = -1; stall_to = -1; stall_seen = 0; clr_bit1 = 1'b0;
    out_dest.delete(); out_cycle.delete(); in_cycle.delete();
    for (int i = 0; i < N; i++) begin
      src_data[i].delete(); src_last[i].delete();
      sb_data[i].delete(); sb_last[i].delete();
      pk_src[i] = 0; beats_src[i] = 0; in_src[i] = 0;
    end
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    enable_mask = '1;
    m_tready = 1'b0;
    vprob = 100; rprob = 100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic add_packet(input int s, input int len);
    for (int b = 0; b < len; b++) begin
      src_data[s].push_back({$urandom, $urandom});
      src_last[s].push_back(b == len - 1);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      if (!s_tvalid[i] && src_data[i].size() > 0 && $urandom_range(99) < vprob) begin
        s_tvalid[i] = 1'b1;
        s_tdata[i*W +: W] = src_data[i][0];
        s_tlast[i] = src_last[i][0];
      end
    end
    m_tready = !(cyc >= stall_from && cyc < stall_to) && ($urandom_range(99) < rprob);
  endtask

  task automatic step();
    logic [N-1:0] cand;
    logic [N-1:0] exp_rdy;
    int hs, pick, d;
    @(negedge clk);
    checks++;
    if (packet_count !== exp_cnt) begin
      errors++;
      $display("FAIL packet_count: got %0h expected %0h (cycle %0d)", packet_count, exp_cnt, cyc);
    end
    checks++;
    if (exp_load) begin
      if (m_tvalid !== 1'b1 || m_tdata !== exp_data || m_tdest !== exp_dest || m_tlast !== exp_ldst) begin
        errors++;
        $display("FAIL out_load: got v=%b d=%h dest=%0d l=%b expected v=1 d=%h dest=%0d l=%b (cycle %0d)",
                 m_tvalid, m_tdata, m_tdest, m_tlast, exp_data, exp_dest, exp_ldst, cyc);
      end
    end else if (prev_mv && !prev_mr) begin
      if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tdest !== prev_dest || m_tlast !== prev_last) begin
        errors++;
        $display("FAIL out_hold: got v=%b d=%h dest=%0d l=%b expected v=1 d=%h dest=%0d l=%b (cycle %0d)",
                 m_tvalid, m_tdata, m_tdest, m_tlast, prev_data, prev_dest, prev_last, cyc);
      end
    end else if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL out_idle: got m_tvalid=%b expected 0 (cycle %0d)", m_tvalid, cyc);
    end
    if (m_tvalid === 1'b1 && !m_tready) stall_seen++;
    if (m_tvalid === 1'b1 && m_tready) begin
      checks++;
      d = int'(m_tdest);
      if (d >= N || sb_data[d].size() == 0) begin
        errors++;
        $display("FAIL out_source: got tdest=%0d with no pending beat expected a pending source (cycle %0d)", d, cyc);
      end else begin
        if (m_tdata !== sb_data[d][0] || m_tlast !== sb_last[d][0]) begin
          errors++;
          $display("FAIL out_order: got d=%h l=%b expected d=%h l=%b (src %0d)",
                   m_tdata, m_tlast, sb_data[d][0], sb_last[d][0], d);
        end
        void'(sb_data[d].pop_front());
        void'(sb_last[d].pop_front());
        beats_src[d]++;
        if (m_tlast) pk_src[d]++;
      end
      out_dest.push_back(d);
      out_cycle.push_back(cyc);
      if (m_tlast === 1'b1) exp_cnt = exp_cnt + 32'd1;
    end
    prev_mv = m_tvalid; prev_mr = m_tready; prev_data = m_tdata; prev_dest = m_tdest; prev_last = m_tlast;

    exp_rdy = '0; hs = -1; pick = -1; owner_next = owner; exp_load = 1'b0;
    if (owner < 0) begin
      checks++;
      if (busy !== 1'b0 || s_tready !== '0) begin
        errors++;
        $display("FAIL idle_ready: got busy=%b s_tready=%b expected busy=0 s_tready=0 (cycle %0d)", busy, s_tready, cyc);
      end
      cand = s_tvalid & enable_mask;
      if (cand != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (pick < 0 && cand[(last_grant + k) % N]) pick = (last_grant + k) % N;
        end
        owner_next = pick;
        last_grant = pick;
      end
    end else begin
      if (!m_tvalid || m_tready) exp_rdy[owner] = 1'b1;
      checks++;
      if (busy !== 1'b1 || s_tready !== exp_rdy) begin
        errors++;
        $display("FAIL stream_ready: got busy=%b s_tready=%b expected busy=1 s_tready=%b (cycle %0d)",
                 busy, s_tready, exp_rdy, cyc);
      end
      if (s_tvalid[owner] && exp_rdy[owner]) begin
        hs = owner;
        sb_data[owner].push_back(src_data[owner][0]);
        sb_last[owner].push_back(src_last[owner][0]);
        exp_load = 1'b1;
        exp_data = src_data[owner][0];
        exp_ldst = src_last[owner][0];
        exp_dest = IW'(owner);
        in_cycle.push_back(cyc);
        in_src[owner]++;
        if (src_last[owner][0]) owner_next = -1;
      end
    end

    @(posedge clk);
    #1;
    owner = owner_next;
    cyc++;
    if (hs >= 0) begin
      void'(src_data[hs].pop_front());
      void'(src_last[hs].pop_front());
      s_tvalid[hs] = 1'b0;
    end
    if (clr_bit1 && owner == 1 && in_src[1] >= 1) begin
      enable_mask[1] = 1'b0;
      clr_bit1 = 1'b0;
    end
    drive_sources();
  endtask

  task automatic run_until_idle(input int budget);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (owner < 0) && !prev_mv && !exp_load;
      for (int i = 0; i < N; i++) begin
        if (enable_mask[i] && (src_data[i].size() != 0 || s_tvalid[i])) done = 1'b0;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: got no idle after %0d cycles expected drained traffic", budget);
    end
    checks++;
    if (sb_data[0].size() + sb_data[1].size() + sb_data[2].size() + sb_data[3].size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d beats never output expected 0",
               sb_data[0].size() + sb_data[1].size() + sb_data[2].size() + sb_data[3].size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tdest !== '0 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h dest=%0d l=%b expected all 0", m_tvalid, m_tdata, m_tdest, m_tlast);
    end
    checks++;
    if (s_tready !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got s_tready=%b busy=%b expected 0", s_tready, busy);
    end
    checks++;
    if (packet_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", packet_count);
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    add_packet(0, 3);
    drive_sources();
    run_until_idle(50);
    checks++;
    if (out_dest.size() != 3 || in_cycle.size() != 3) begin
      errors++;
      $display("FAIL single_beats: got %0d out / %0d in expected 3", out_dest.size(), in_cycle.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (out_dest[k] != 0 || out_cycle[k] != in_cycle[k] + 1) begin
          errors++;
          $display("FAIL single_latency: got dest=%0d out_cycle=%0d expected dest=0 out_cycle=%0d",
                   out_dest[k], out_cycle[k], in_cycle[k] + 1);
        end
      end
    end
    checks++;
    if (packet_count !== 32'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got count=%0d busy=%b expected count=1 busy=0", packet_count, busy);
    end
  endtask

  task automatic test_back_to_back();
    int exp_seq[10];
    exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    do_reset();
    for (int s = 0; s < N; s++) begin
      for (int p = 0; p < 3; p++) add_packet(s, 2);
    end
    drive_sources();
    run_until_idle(200);
    checks++;
    if (out_dest.size() != 24) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats expected 24", out_dest.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (out_dest[k] != exp_seq[k]) begin
          errors++;
          $display("FAIL b2b_order: got tdest=%0d at beat %0d expected %0d", out_dest[k], k, exp_seq[k]);
        end
      end
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (out_cycle[2*p+1] - out_cycle[2*p] != 1 || out_cycle[2*p+2] - out_cycle[2*p+1] != 2) begin
          errors++;
          $display("FAIL b2b_gap: got gaps %0d/%0d after packet %0d expected 1/2",
                   out_cycle[2*p+1] - out_cycle[2*p], out_cycle[2*p+2] - out_cycle[2*p+1], p);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    add_packet(2, 6);
    stall_from = 4;
    stall_to = 9;
    drive_sources();
    run_until_idle(100);
    checks++;
    if (stall_seen != 5 || out_dest.size() != 6) begin
      errors++;
      $display("FAIL stall: got %0d stalled cycles %0d beats expected 5 stalled 6 beats", stall_seen, out_dest.size());
    end
  endtask

  task automatic test_enable_mask();
    do_reset();
    enable_mask = 4'b1010;
    rprob = 75;
    for (int s = 0; s < N; s++) begin
      for (int p = 0; p < 3; p++) add_packet(s, 3);
    end
    clr_bit1 = 1'b1;
    drive_sources();
    run_until_idle(300);
    checks++;
    if (beats_src[0] != 0 || beats_src[2] != 0) begin
      errors++;
      $display("FAIL mask_disabled: got %0d/%0d beats from src0/src2 expected 0", beats_src[0], beats_src[2]);
    end
    checks++;
    if (pk_src[1] != 1 || pk_src[3] != 3) begin
      errors++;
      $display("FAIL mask_packets: got src1=%0d src3=%0d packets expected 1 and 3", pk_src[1], pk_src[3]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.packet_count_q = 32'hFFFF_FFFF;
    #1 release dut.packet_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    add_packet(3, 2);
    drive_sources();
    run_until_idle(50);
    checks++;
    if (packet_count !== 32'd0) begin
      errors++;
      $display("FAIL wrap: got %0h expected 0", packet_count);
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    do_reset();
    add_packet(2, 4);
    drive_sources();
    n = 0;
    while (in_src[2] < 2 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (in_src[2] < 2) begin
      errors++;
      $display("FAIL rst_mid_reach: got %0d beats accepted expected 2", in_src[2]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b s_tready=%b busy=%b expected 0", m_tvalid, s_tready, busy);
    end
    rst = 1'b0;
    model_reset();
    for (int s = 0; s < N; s++) add_packet(s, 2);
    drive_sources();
    run_until_idle(200);
    checks++;
    if (out_dest.size() == 0 || out_dest[0] != 0) begin
      errors++;
      $display("FAIL rst_mid_grant: got first tdest=%0d expected 0", (out_dest.size() == 0) ? -1 : out_dest[0]);
    end
  endtask

  task automatic test_random();
    int s;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      enable_mask = N'($urandom_range(1, 15));
      vprob = 30 + $urandom_range(0, 70);
      rprob = 30 + $urandom_range(0, 70);
      for (int p = 0; p < 14; p++) begin
        s = $urandom_range(0, N - 1);
        add_packet(s, $urandom_range(1, 5));
      end
      drive_sources();
      run_until_idle(3000);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable_mask = '1;
    m_tready = 1'b0;
    model_reset();
    vprob = 100;
    rprob = 100;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_stall();
    test_enable_mask();
    test_wrap();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
